// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the fetch PC and the IF/ID pipeline register.
// The instruction memory is combinational and external; InstrF only ever reaches a flop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignD
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_plus4_f;

  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic        valid_id_q, valid_id_d;
  logic        misalign_id_q, misalign_id_d;

  // Wraps silently at the top of the address space.
  assign pc_plus4_f = pc_f_q + 32'd4;

  // Redirect from EX outranks a fetch stall so a taken branch is never lost.
  always_comb begin
    pc_f_d = pc_plus4_f;
    if (PCSrcE) begin
      pc_f_d = PCTargetE;
    end else if (StallF) begin
      pc_f_d = pc_f_q;
    end
  end

  // Flush outranks stall: a squashed slot must not be held as a live instruction.
  always_comb begin
    instr_id_d    = InstrF;
    pc_id_d       = pc_f_q;
    pc_plus4_id_d = pc_plus4_f;
    valid_id_d    = 1'b1;
    misalign_id_d = (pc_f_q[1:0] != 2'b00);
    if (FlushD) begin
      instr_id_d    = NOP_INSTR;
      pc_id_d       = 32'd0;
      pc_plus4_id_d = 32'd0;
      valid_id_d    = 1'b0;
      misalign_id_d = 1'b0;
    end else if (StallD) begin
      instr_id_d    = instr_id_q;
      pc_id_d       = pc_id_q;
      pc_plus4_id_d = pc_plus4_id_q;
      valid_id_d    = valid_id_q;
      misalign_id_d = misalign_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f_q        <= RESET_PC;
      instr_id_q    <= NOP_INSTR;
      pc_id_q       <= 32'd0;
      pc_plus4_id_q <= 32'd0;
      valid_id_q    <= 1'b0;
      misalign_id_q <= 1'b0;
    end else begin
      pc_f_q        <= pc_f_d;
      instr_id_q    <= instr_id_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_id_q    <= valid_id_d;
      misalign_id_q <= misalign_id_d;
    end
  end

  assign PCF       = pc_f_q;
  assign InstrD    = instr_id_q;
  assign PCD       = pc_id_q;
  assign PCPlus4D  = pc_plus4_id_q;
  assign ValidD    = valid_id_q;
  assign MisalignD = misalign_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table from reset through stall, redirect,
// priority, misalign, wrap and mid-run reset, then randomized legal hazard traffic.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pcf;
  logic [31:0] instr_f;
  logic        stall_f, stall_d, flush_d, pcsrc_e;
  logic [31:0] pctarget_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_d;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PCF       (pcf),
    .InstrF    (instr_f),
    .StallF    (stall_f),
    .StallD    (stall_d),
    .FlushD    (flush_d),
    .PCSrcE    (pcsrc_e),
    .PCTargetE (pctarget_e),
    .InstrD    (instr_d),
    .PCD       (pc_d),
    .PCPlus4D  (pc_plus4_d),
    .ValidD    (valid_d),
    .MisalignD (misalign_d)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    case (idx)
      30'd0:   mem_word = 32'hFFC4_A303;
      30'd1:   mem_word = 32'h0064_A423;
      30'd2:   mem_word = 32'h0062_E233;
      30'd3:   mem_word = 32'hFE42_0AE3;
      default: mem_word = {addr[31:2], 2'b00} ^ 32'h5A5A_0F13;
    endcase
  endfunction

  assign instr_f = rst ? mem_word(pcf) : 32'd0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
  logic        m_valid, m_mis;

  // One clock edge of the fetch stage, from the rules in words: reset first,
  // then PC = target / hold / +4, and IF/ID = bubble / hold / fetched slot.
  task automatic model_edge();
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    if (!rst) begin
      m_pc = 32'd0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_mis = 0;
    end else begin
      if (pcsrc_e)       m_pc = pctarget_e;
      else if (!stall_f) m_pc = fetched_pc + 4;
      if (flush_d) begin
        m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_mis = 0;
      end else if (!stall_d) begin
        m_instr = mem_word(fetched_pc);
        m_pcd   = fetched_pc;
        m_pcp4  = fetched_pc + 4;
        m_valid = 1;
        m_mis   = (fetched_pc % 4) != 0;
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pcf"},   pcf,                m_pc);
    chk({tag, ".instr"}, instr_d,            m_instr);
    chk({tag, ".pcd"},   pc_d,               m_pcd);
    chk({tag, ".pcp4"},  pc_plus4_d,         m_pcp4);
    chk({tag, ".valid"}, {31'd0, valid_d},   {31'd0, m_valid});
    chk({tag, ".mis"},   {31'd0, misalign_d}, {31'd0, m_mis});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    rst = r; stall_f = sf; stall_d = sd; flush_d = fd; pcsrc_e = ps; pctarget_e = tgt;
  endtask

  task automatic clock_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, sf, sd, fd, ps;
    logic [31:0] tgt;
    logic [31:0] e_pcf, e_instr, e_pcd, e_pcp4;
    logic        e_valid, e_mis;
  } vec_t;

  vec_t vecs[20];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_mis = 0;

    //            rst sf sd fd ps  tgt            pcf            instr                    pcd            pcp4    v  mis
    vecs[0]  = '{1'b0,0,0,0,0, 32'd0,         32'd0,         NOP,                     32'd0,         32'd0,  0, 0};
    vecs[1]  = '{1'b0,0,0,0,0, 32'd0,         32'd0,         NOP,                     32'd0,         32'd0,  0, 0};
    vecs[2]  = '{1'b0,0,0,0,0, 32'd0,         32'd0,         NOP,                     32'd0,         32'd0,  0, 0};
    vecs[3]  = '{1'b1,0,0,0,0, 32'd0,         32'h4,         32'hFFC4_A303,           32'h0,         32'h4,  1, 0};
    vecs[4]  = '{1'b1,0,0,0,0, 32'd0,         32'h8,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[5]  = '{1'b1,1,1,0,0, 32'd0,         32'h8,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[6]  = '{1'b1,1,1,0,0, 32'd0,         32'h8,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[7]  = '{1'b1,0,0,0,0, 32'd0,         32'hC,         32'h0062_E233,           32'h8,         32'hC,  1, 0};
    vecs[8]  = '{1'b1,0,0,1,1, 32'h4,         32'h4,         NOP,                     32'h0,         32'h0,  0, 0};
    vecs[9]  = '{1'b1,0,0,0,0, 32'd0,         32'h8,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[10] = '{1'b1,1,1,1,1, 32'h0,         32'h0,         NOP,                     32'h0,         32'h0,  0, 0};
    vecs[11] = '{1'b1,0,0,0,0, 32'd0,         32'h4,         32'hFFC4_A303,           32'h0,         32'h4,  1, 0};
    vecs[12] = '{1'b1,0,0,0,1, 32'h6,         32'h6,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[13] = '{1'b1,0,0,0,0, 32'd0,         32'hA,         32'h0064_A423,           32'h6,         32'hA,  1, 1};
    vecs[14] = '{1'b1,0,0,1,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,                     32'h0,         32'h0,  0, 0};
    vecs[15] = '{1'b1,0,0,0,0, 32'd0,         32'h0,         mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,  1, 0};
    vecs[16] = '{1'b1,0,0,0,0, 32'd0,         32'h4,         32'hFFC4_A303,           32'h0,         32'h4,  1, 0};
    vecs[17] = '{1'b1,0,0,0,0, 32'd0,         32'h8,         32'h0064_A423,           32'h4,         32'h8,  1, 0};
    vecs[18] = '{1'b0,1,0,0,0, 32'd0,         32'h0,         NOP,                     32'h0,         32'h0,  0, 0};
    vecs[19] = '{1'b1,0,0,0,0, 32'd0,         32'h4,         32'hFFC4_A303,           32'h0,         32'h4,  1, 0};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
      clock_edge();
      chk($sformatf("vec%0d.pcf", i),   pcf,              vecs[i].e_pcf);
      chk($sformatf("vec%0d.instr", i), instr_d,          vecs[i].e_instr);
      chk($sformatf("vec%0d.pcd", i),   pc_d,             vecs[i].e_pcd);
      chk($sformatf("vec%0d.pcp4", i),  pc_plus4_d,       vecs[i].e_pcp4);
      chk($sformatf("vec%0d.valid", i), {31'd0, valid_d}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.mis", i),   {31'd0, misalign_d}, {31'd0, vecs[i].e_mis});
      chk_model($sformatf("vec%0d.model", i));
    end

    // Hand sequence: three-cycle load-use stall mid-stream, stream must resume without gaps.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    clock_edge();
    chk("seq.pre_stall.pcd", pc_d, 32'h4);
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      clock_edge();
      chk("seq.stall.pcd", pc_d, 32'h4);
      chk("seq.stall.pcf", pcf, 32'h8);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    clock_edge();
    chk("seq.resume.pcd", pc_d, 32'h8);
    chk("seq.resume.instr", instr_d, 32'h0062_E233);
    clock_edge();
    chk("seq.next.pcd", pc_d, 32'hC);
    chk("seq.next.instr", instr_d, 32'hFE42_0AE3);

    // Randomized legal hazard traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic r, sf, sd, ps, fd;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 39) != 0);
      sf = ($urandom_range(0, 3) == 0);
      sd = sf && ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 5) == 0);
      fd = ps || ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = {$urandom_range(0, 7), 2'b00};
        1:       tgt = 32'hFFFF_FFF0 | {$urandom_range(0, 3), 2'b00};
        2:       tgt = $urandom;
        default: tgt = {$urandom_range(0, 255), 2'b00} | 32'(ps ? $urandom_range(0, 3) : 0);
      endcase
      drive(r, sf, sd, fd, ps, tgt);
      clock_edge();
      chk_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the RV32I 5-stage pipeline.
- Owns the program counter and drives the instruction-memory address. The instruction memory is combinational, word-indexed by address bits [31:2], and returns 0 while rst is low.
- Captures the returned word into the IF/ID pipeline register.
- Handles sequential PC+4 advance, taken-branch/jump redirect from EX, load-use stalls and decode flushes from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in InstrD on reset/flush.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising edge of clk).
- PCF  output  32  fetch PC; drives instruction-memory address A.
- InstrF  input  32  instruction word from memory (RD) for PCF, same cycle.
- StallF  input  1  hold PCF.
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  replace IF/ID contents with bubble.
- PCSrcE  input  1  taken branch/jump resolved in EX.
- PCTargetE  input  32  redirect target from EX.
- InstrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real fetched instruction.
- MisalignD  output  1  IF/ID PC was not word-aligned (instruction-address-misaligned).

Behaviour:
- Reset (rst=0 at edge):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0.
  - Reset overrides every other input.
- Reset release:
  - First edge with rst=1 captures InstrF for RESET_PC into IF/ID.
  - PCF advances to RESET_PC+4 on that same edge.
- PCPlus4F = PCF + 32'd4, internal, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Next-PC priority, highest first:
  - rst=0 -> RESET_PC.
  - PCSrcE=1 -> PCTargetE. Redirect wins over StallF.
  - StallF=1 -> PCF unchanged.
  - else -> PCPlus4F.
- IF/ID priority, highest first:
  - rst=0 -> reset values.
  - FlushD=1 -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0. Flush wins over StallD.
  - StallD=1 -> all IF/ID outputs hold.
  - else -> InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1, MisalignD=(PCF[1:0]!=0).
- Latency: the word fetched at PCF in cycle n appears on InstrD in cycle n+1. The block adds no combinational path from InstrF to any output.
- Misaligned target:
  - PCTargetE with bits[1:0]!=0 is loaded into PCF unmodified.
  - MisalignD flags it when captured. The memory ignores bits [1:0].
  - The block does not trap.
- Redirect contract: the hazard unit asserts FlushD together with PCSrcE so the wrong-path word in IF is squashed. The block does not auto-flush.
- Load-use stall: StallF=1 and StallD=1 together hold both PCF and IF/ID for exactly the stalled cycles. No instruction is lost or duplicated.
- StallD=1 with StallF=0 is illegal from the hazard unit. The block still obeys the rules above (the skipped word is dropped). Verification flags this as an assertion.

Test Plan:
- Reset/sequence: memory {0:FFC4A303, 1:0064A423, 2:0062E233, 3:FE420AE3}; hold rst=0 for 3 cycles, then release -> PCF=0 during reset, InstrD=00000013, ValidD=0. Next edges give (InstrD,PCD) = (FFC4A303,0), (0064A423,4), (0062E233,8), (FE420AE3,C). PCPlus4D=PCD+4.
- Stall: StallF=StallD=1 for 2 cycles while PCF=8 -> PCF stays 8 and InstrD stays 0064A423 for 2 cycles. On release, InstrD=0062E233 and PCD=8; no duplicate.
- Redirect+flush: with PCF=C, pulse PCSrcE=1, PCTargetE=4, FlushD=1 -> next cycle PCF=4, InstrD=00000013, ValidD=0. Following cycle InstrD=0064A423, PCD=4.
- Priority: PCSrcE=1, StallF=1, FlushD=1, StallD=1 in one cycle, PCTargetE=0 -> PCF=0, InstrD=NOP, ValidD=0.
- Misalign/wrap: PCTargetE=32'h0000_0006 -> PCD=6, MisalignD=1. Force PCF=FFFFFFFC via redirect -> PCPlus4D=0 and next PCF=0.
- Mid-run reset: assert rst=0 for 1 cycle while PCF=8 and StallF=1 -> PCF=RESET_PC and all IF/ID outputs return to reset values on that edge.
